// File: rtl/adder_bist_pkg.sv
// Shared state encoding and constants for the adder BIST controller.
package adder_bist_pkg;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} bist_state_e;

  localparam int          ERR_W          = 8;
  localparam logic [31:0] BIST_LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/adder_bist_lfsr.sv
// 32-bit right-shifting Galois LFSR with synchronous load and step.
// Only built when ADDER_BIST_LFSR_EN is defined (pseudo-random vector mode).
`ifdef ADDER_BIST_LFSR_EN
module adder_bist_lfsr
  import adder_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i)
      state_d = SEED;
    else if (step_i)
      state_d = state_q[0] ? ((state_q >> 1) ^ BIST_LFSR_POLY) : (state_q >> 1);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule
`endif

// File: rtl/adder_bist.sv
// BIST controller: sweeps {a,b,cin} into an adder, checks sum/cout against a+b+cin.
// ADDER_BIST_LFSR_EN selects NUM_VECTORS pseudo-random vectors instead of the exhaustive sweep.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int          WIDTH         = 1,
  parameter int          SETTLE_CYCLES = 1,
  parameter int          NUM_VECTORS   = 64,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_cin,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH:0]   first_fail_vec,
  output logic               first_fail_valid
);

  localparam int VW  = 2*WIDTH + 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  bist_state_e      state_q, state_d;
  logic [SCW-1:0]   settle_q, settle_d;
  logic [VW-1:0]    drv_q, drv_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VW-1:0]    ffv_q, ffv_d;
  logic             ffval_q, ffval_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             vec_clr, vec_adv, vec_last;
  logic [VW-1:0]    cur_vec;
  logic [WIDTH:0]   golden;
  logic             mism;

`ifdef ADDER_BIST_LFSR_EN
  logic [31:0] lfsr_state;
  logic [31:0] rem_q, rem_d;
  logic        unused_lfsr;

  adder_bist_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (vec_clr),
    .step_i  (state_q == CHECK),
    .state_o (lfsr_state)
  );

  // Run length is tracked separately; the LFSR never reaches a terminal value.
  always_comb begin
    rem_d = rem_q;
    if (vec_clr)      rem_d = 32'(NUM_VECTORS - 1);
    else if (vec_adv) rem_d = rem_q - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) rem_q <= '0;
    else       rem_q <= rem_d;
  end

  assign cur_vec     = lfsr_state[VW-1:0];
  assign vec_last    = (rem_q == '0);
  assign unused_lfsr = ^lfsr_state[31:VW];
`else
  logic [VW-1:0] vec_q, vec_d;
  logic [31:0]   unused_cfg;

  always_comb begin
    vec_d = vec_q;
    if (vec_clr)      vec_d = '0;
    else if (vec_adv) vec_d = vec_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) vec_q <= '0;
    else       vec_q <= vec_d;
  end

  assign cur_vec    = vec_q;
  assign vec_last   = &vec_q;
  assign unused_cfg = 32'(NUM_VECTORS) ^ LFSR_SEED;
`endif

  assign golden = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
  assign mism   = (golden != {dut_cout, dut_sum});

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    drv_d    = drv_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffval_d  = ffval_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    vec_clr  = 1'b0;
    vec_adv  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          vec_clr = 1'b1;
          err_d   = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        drv_d    = cur_vec;
        busy_d   = 1'b1;
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SCW'(SETTLE_CYCLES - 1)) state_d = CHECK;
        else                                      settle_d = settle_q + 1'b1;
      end
      CHECK: begin
        if (mism) begin
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
          if (!ffval_q) begin
            ffv_d   = drv_q;
            ffval_d = 1'b1;
          end
        end
        if (vec_last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          vec_adv = 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      drv_q    <= '0;
      err_q    <= '0;
      ffv_q    <= '0;
      ffval_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      drv_q    <= drv_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffval_q  <= ffval_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_a            = drv_q[VW-1:WIDTH+1];
  assign dut_b            = drv_q[WIDTH:1];
  assign dut_cin          = drv_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: two instances (WIDTH=1 and WIDTH=4) driving a faultable adder model,
// results compared against a vector-by-vector reference model of the whole run.
module tb_adder_bist;

  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam int          NV   = 64;
  localparam int          S1   = 1;
  localparam int          S4   = 2;
`ifdef ADDER_BIST_LFSR_EN
  localparam bit LFSR = 1'b1;
`else
  localparam bit LFSR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, st1, st4;

  logic [0:0] a1, b1, sum1;
  logic       cin1, cout1, busy1, done1, pass1, ffval1;
  logic [7:0] err1;
  logic [2:0] ffv1;

  logic [3:0] a4, b4, sum4;
  logic       cin4, cout4, busy4, done4, pass4, ffval4;
  logic [7:0] err4;
  logic [8:0] ffv4;

  int mode1 = 0, tgt1 = 0, mode4 = 0, tgt4 = 0;
  int n_cmp = 0, n_fail = 0;

  // Adder under test with injectable faults:
  // 1 cout stuck-0, 2 sum[0] stuck-0, 3 sum[0] flipped on vector tgt, 4 sum MSB stuck-1.
  function automatic logic [8:0] adder_ut(int w, int mode, int tgt, int v);
    int a, b, c, r;
    a = (v >> (w + 1)) & ((1 << w) - 1);
    b = (v >> 1) & ((1 << w) - 1);
    c = v & 1;
    r = a + b + c;
    case (mode)
      1:       r = r & ~(1 << w);
      2:       r = r & ~1;
      3:       if (v == tgt) r = r ^ 1;
      4:       r = r | (1 << (w - 1));
      default: ;
    endcase
    return 9'(r);
  endfunction

  assign {cout1, sum1} = 2'(adder_ut(1, mode1, tgt1, int'({a1, b1, cin1})));
  assign {cout4, sum4} = 5'(adder_ut(4, mode4, tgt4, int'({a4, b4, cin4})));

  adder_bist #(.WIDTH(1), .SETTLE_CYCLES(S1), .NUM_VECTORS(NV), .LFSR_SEED(SEED)) u1 (
    .clk(clk), .reset(reset), .start(st1),
    .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_sum(sum1), .dut_cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  adder_bist #(.WIDTH(4), .SETTLE_CYCLES(S4), .NUM_VECTORS(NV), .LFSR_SEED(SEED)) u4 (
    .clk(clk), .reset(reset), .start(st4),
    .dut_a(a4), .dut_b(b4), .dut_cin(cin4), .dut_sum(sum4), .dut_cout(cout4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_fail_vec(ffv4), .first_fail_valid(ffval4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-run reference: walk the vector list, count mismatching vectors, note the first.
  task automatic model(input int w, input int mode, input int tgt, output int n, output int err,
                       output int ffv, output int ffval, output int first_v, output int last_v);
    logic [31:0] s;
    int v, mask, gold;
    mask = (1 << (2*w + 1)) - 1;
    n = LFSR ? NV : mask + 1;
    s = SEED; err = 0; ffv = 0; ffval = 0; first_v = 0; last_v = 0;
    for (int k = 0; k < n; k++) begin
      v = LFSR ? (int'(s) & mask) : k;
      if (k == 0) first_v = v;
      last_v = v;
      gold = (v >> (w + 1)) + ((v >> 1) & ((1 << w) - 1)) + (v & 1);
      if (int'(adder_ut(w, mode, tgt, v)) != gold) begin
        if (ffval == 0) begin ffval = 1; ffv = v; end
        err++;
      end
      s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    end
    if (err > 255) err = 255;
  endtask

  task automatic get(input int inst, output logic bz, output logic dn, output logic ps,
                     output logic [31:0] ec, output logic [31:0] fv, output logic [31:0] fvl,
                     output logic [31:0] vec);
    if (inst == 1) begin
      bz = busy1; dn = done1; ps = pass1; ec = 32'(err1); fv = 32'(ffv1);
      fvl = 32'(ffval1); vec = 32'({a1, b1, cin1});
    end else begin
      bz = busy4; dn = done4; ps = pass4; ec = 32'(err4); fv = 32'(ffv4);
      fvl = 32'(ffval4); vec = 32'({a4, b4, cin4});
    end
  endtask

  // One full run; optional extra start pulses sampled at edges 5 and 12 (instance 1 only).
  task automatic run(input int inst, input int mode, input int tgt, input int settle,
                     input int w, input bit pulses);
    int n, err, ffv, ffval, first_v, last_v, cyc;
    logic bz, dn, ps;
    logic [31:0] ec, fv, fvl, vec;
    if (inst == 1) begin mode1 = mode; tgt1 = tgt; end
    else           begin mode4 = mode; tgt4 = tgt; end
    model(w, mode, tgt, n, err, ffv, ffval, first_v, last_v);
    @(negedge clk);
    if (inst == 1) st1 = 1'b1; else st4 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0; st4 = 1'b0;
    get(inst, bz, dn, ps, ec, fv, fvl, vec);
    chk("done_cleared", 32'(dn), 0);
    chk("err_cleared", ec, 0);
    chk("ffvalid_cleared", fvl, 0);
    @(posedge clk); #1;
    get(inst, bz, dn, ps, ec, fv, fvl, vec);
    chk("busy_edge1", 32'(bz), 1);
    chk("first_vector", vec, 32'(first_v));
    cyc = 1;
    while (!dn && cyc < n*(settle + 2) + 20) begin
      @(negedge clk);
      if (inst == 1) st1 = pulses && (cyc == 4 || cyc == 11);
      @(posedge clk); #1;
      st1 = 1'b0;
      cyc++;
      get(inst, bz, dn, ps, ec, fv, fvl, vec);
      chk("busy_done_excl", 32'(bz & dn), 0);
    end
    chk("done_cycle", 32'(cyc), 32'(n*(settle + 2)));
    chk("busy_at_done", 32'(bz), 0);
    chk("pass", 32'(ps), 32'(err == 0));
    chk("err_count", ec, 32'(err));
    chk("ff_valid", fvl, 32'(ffval));
    chk("ff_vec", fv, 32'(ffv));
    chk("last_vec_held", vec, 32'(last_v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bz, dn, ps;
    logic [31:0] ec, fv, fvl, vec;
    reset = 1'b1; st1 = 1'b0; st4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i += 3) begin
      get(i, bz, dn, ps, ec, fv, fvl, vec);
      chk("rst_outputs", {24'd0, bz, dn, ps, 1'b0, |ec, |fv, |fvl, |vec}, 0);
    end
    @(negedge clk); reset = 1'b0;

    // Fault-free, then cout stuck-0, then a run started from DONE with mid-run start pulses.
    run(1, 0, 0, S1, 1, 1'b0);
    run(1, 1, 0, S1, 1, 1'b0);
`ifndef ADDER_BIST_LFSR_EN
    chk("cout_sa0_err", 32'(err1), 4);
    chk("cout_sa0_ffv", 32'(ffv1), 3);
    chk("cout_sa0_pass", 32'(pass1), 0);
`endif
    run(1, 0, 0, S1, 1, 1'b1);

    // Mid-run reset at edge 10, then a clean full run.
    mode1 = 3; tgt1 = 1;
    @(negedge clk); st1 = 1'b1;
    @(posedge clk); #1; st1 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
`ifndef ADDER_BIST_LFSR_EN
    chk("err_before_rst", 32'(err1), 1);
`endif
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    get(1, bz, dn, ps, ec, fv, fvl, vec);
    chk("midrun_rst_outputs", {24'd0, bz, dn, ps, 1'b0, |ec, |fv, |fvl, |vec}, 0);
    @(negedge clk); reset = 1'b0;
    run(1, 3, 1, S1, 1, 1'b0);

    // Wide adder, sum[0] stuck-0: saturating error count.
    run(4, 2, 0, S4, 4, 1'b0);
`ifndef ADDER_BIST_LFSR_EN
    chk("sat_err", 32'(err4), 255);
    chk("sat_ffv", 32'(ffv4), 1);
`endif

    repeat (3) run(4, int'($urandom_range(0, 4)), int'($urandom_range(0, 511)), S4, 4, 1'b0);
    repeat (4) run(1, int'($urandom_range(0, 4)), int'($urandom_range(0, 7)), S1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
